// File: rtl/reg_wr_decoder.sv
// reg_wr_decoder: registered N-to-2^N register-file write-enable decoder with a
// self-timed clear sweep that pulses every write line once, in index order.
module reg_wr_decoder #(
  parameter int ADDR_W    = 5,
  parameter int ZERO_MASK = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [ADDR_W-1:0]    a,
  input  logic                 clear_req,
  output logic [2**ADDR_W-1:0] y,
  output logic [ADDR_W-1:0]    sweep_addr,
  output logic                 busy,
  output logic                 done
);
  localparam int N = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] START = ADDR_W'(ZERO_MASK != 0);
  localparam logic [ADDR_W-1:0] MAX = '1;
  typedef enum logic {IDLE, SWEEP} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] cnt, cnt_n, inc, sa_n;
  logic [N-1:0] y_n;
  logic busy_n, done_n;
  assign inc = cnt + ADDR_W'(1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      y          <= '0;
      sweep_addr <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      y          <= y_n;
      sweep_addr <= sa_n;
      busy       <= busy_n;
      done       <= done_n;
    end
  // clear_req beats a same-cycle write; sweep ends at MAX so cnt never wraps
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    y_n     = '0;
    sa_n    = '0;
    busy_n  = 1'b0;
    done_n  = 1'b0;
    if (state == IDLE) begin
      if (clear_req) begin
        state_n = SWEEP;
        cnt_n   = START;
        y_n     = N'(1) << START;
        sa_n    = START;
        busy_n  = 1'b1;
      end else
        y_n = (en && !(ZERO_MASK != 0 && a == '0)) ? N'(1) << a : '0;
    end else if (cnt != MAX) begin
      cnt_n  = inc;
      y_n    = N'(1) << inc;
      sa_n   = inc;
      busy_n = 1'b1;
    end else begin
      state_n = IDLE;
      cnt_n   = '0;
      done_n  = 1'b1;
    end
  end
endmodule

// File: tb/tb_reg_wr_decoder.sv
// tb_reg_wr_decoder: directed checks of decode, gating, sweep, back-to-back clear and async reset.
module tb_reg_wr_decoder;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b0;
  logic [4:0] a = '0;
  logic clear_req = 1'b0;
  logic clear0 = 1'b0;
  logic [31:0] y, y1;
  logic [4:0] sa, sa1;
  logic busy, done, busy1, done1;
  int pass = 0;
  int total = 0;
  reg_wr_decoder dut (.clk(clk), .rst(rst), .en(en), .a(a), .clear_req(clear_req),
                      .y(y), .sweep_addr(sa), .busy(busy), .done(done));
  reg_wr_decoder #(.ADDR_W(5), .ZERO_MASK(0)) dut_nomask (.clk(clk), .rst(rst), .en(en), .a(a),
                      .clear_req(clear0), .y(y1), .sweep_addr(sa1), .busy(busy1), .done(done1));
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    #1 rst = 1'b1;
    #10;
    total++;
    if ({y, sa, busy, done, y1} !== '0) $display("FAIL reset: got y=%h sa=%0d busy=%b done=%b y1=%h, want all 0", y, sa, busy, done, y1);
    else pass++;
    #1 rst = 1'b0;
  endtask
  task automatic test_decode;
    logic [31:0] exp;
    for (int i = 0; i < 32; i++) begin
      a = 5'(i);
      en = 1'b1;
      tick();
      exp = (i == 0) ? 32'h0 : 32'(1) << i;
      total++;
      if ({y, busy, done} !== {exp, 2'b00}) $display("FAIL decode a=%0d: got y=%h busy=%b done=%b, want y=%h busy=0 done=0", i, y, busy, done, exp);
      else pass++;
    end
  endtask
  task automatic test_enable;
    en = 1'b0;
    a = 5'b10101;
    tick();
    total++;
    if (y !== 32'h0) $display("FAIL en_off: got y=%h, want 00000000", y);
    else pass++;
    en = 1'b1;
    tick();
    total++;
    if (y !== 32'h0020_0000) $display("FAIL en_on: got y=%h, want 00200000", y);
    else pass++;
    a = 5'd0;
    tick();
    total++;
    if ({y, y1} !== {32'h0, 32'h1}) $display("FAIL zero_mask a=0: got y=%h y1=%h, want y=00000000 y1=00000001", y, y1);
    else pass++;
    en = 1'b0;
  endtask
  task automatic test_sweep(input bit scramble);
    en = 1'b1;
    a = 5'd7;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int i = 1; i < 32; i++) begin
      total++;
      if ({y, sa, busy, done} !== {32'(1) << i, 5'(i), 2'b10})
        $display("FAIL sweep%0d i=%0d: got y=%h sa=%0d busy=%b done=%b, want y=%h sa=%0d busy=1 done=0", scramble, i, y, sa, busy, done, 32'(1) << i, i);
      else pass++;
      if (scramble) begin
        en = 1'($urandom_range(0, 1));
        a = 5'($urandom_range(0, 31));
        clear_req = 1'($urandom_range(0, 1));
      end
      tick();
    end
    en = 1'b0;
    clear_req = 1'b0;
    total++;
    if ({y, sa, busy, done} !== {32'h0, 5'd0, 2'b01}) $display("FAIL sweep_done%0d: got y=%h sa=%0d busy=%b done=%b, want y=0 sa=0 busy=0 done=1", scramble, y, sa, busy, done);
    else pass++;
    tick();
    total++;
    if ({y, busy, done} !== {32'h0, 2'b00}) $display("FAIL post_sweep%0d: got y=%h busy=%b done=%b, want all 0", scramble, y, busy, done);
    else pass++;
  endtask
  task automatic test_sweep_nomask;
    clear0 = 1'b1;
    tick();
    clear0 = 1'b0;
    for (int i = 0; i < 32; i++) begin
      total++;
      if ({y1, sa1, busy1, done1} !== {32'(1) << i, 5'(i), 2'b10})
        $display("FAIL nomask_sweep i=%0d: got y=%h sa=%0d busy=%b done=%b, want y=%h sa=%0d busy=1", i, y1, sa1, busy1, done1, 32'(1) << i, i);
      else pass++;
      tick();
    end
    total++;
    if ({y1, busy1, done1} !== {32'h0, 2'b01}) $display("FAIL nomask_done: got y=%h busy=%b done=%b, want y=0 busy=0 done=1", y1, busy1, done1);
    else pass++;
    tick();
  endtask
  task automatic test_back_to_back;
    clear_req = 1'b1;
    tick();
    for (int i = 1; i < 32; i++) tick();
    total++;
    if ({busy, done} !== 2'b01) $display("FAIL b2b_done: got busy=%b done=%b, want busy=0 done=1", busy, done);
    else pass++;
    tick();
    clear_req = 1'b0;
    total++;
    if ({y, busy, done} !== {32'h2, 2'b10}) $display("FAIL b2b_restart: got y=%h busy=%b done=%b, want y=00000002 busy=1 done=0", y, busy, done);
    else pass++;
  endtask
  task automatic test_reset_mid_sweep;
    int dones = 0;
    for (int i = 0; i < 11; i++) tick();
    total++;
    if (sa !== 5'd12) $display("FAIL pre_reset_addr: got sa=%0d, want 12", sa);
    else pass++;
    #2 rst = 1'b1;
    #1;
    total++;
    if ({y, sa, busy, done} !== '0) $display("FAIL async_reset: got y=%h sa=%0d busy=%b done=%b, want all 0", y, sa, busy, done);
    else pass++;
    rst = 1'b0;
    en = 1'b1;
    a = 5'd3;
    tick();
    total++;
    if ({y, busy, done} !== {32'h8, 2'b00}) $display("FAIL post_reset_decode: got y=%h busy=%b done=%b, want y=00000008 busy=0 done=0", y, busy, done);
    else pass++;
    en = 1'b0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (done || busy) dones++;
    end
    total++;
    if (dones !== 0) $display("FAIL no_done_after_reset: got %0d busy/done cycles, want 0", dones);
    else pass++;
  endtask
  initial begin
    test_reset();
    test_decode();
    test_enable();
    test_sweep(1'b0);
    test_sweep(1'b1);
    test_sweep_nomask();
    test_back_to_back();
    test_reset_mid_sweep();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/reg_wr_decoder.md
# reg_wr_decoder

Parametrised, registered N-to-2^N write-enable decoder for the MIPS register file, successor to the combinational 5-to-32 decoder. It adds an enable input, a registered one-hot output, optional suppression of register 0 (the hardwired `$zero`), and a self-timed clear sweep that asserts every write line once, in order, so the register file can be zeroed without software. It sits between the writeback stage (address/enable) and the register-file write ports.

## Interface
- `ADDR_W`, default 5: address width; output width is `2**ADDR_W`.
- `ZERO_MASK`, default 1: when 1, code 0 never asserts `y[0]`, and the sweep skips index 0.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  write enable from writeback.
- `a`  in  ADDR_W  write register address.
- `clear_req`  in  1  request a clear sweep; sampled in IDLE only.
- `y`  out  2**ADDR_W  registered one-hot write-enable vector, or all zeros.
- `sweep_addr`  out  ADDR_W  index currently driven during a sweep; 0 outside a sweep.
- `busy`  out  1  high while `y` carries sweep outputs.
- `done`  out  1  one-cycle pulse after the last sweep output.

## Operation
- States: IDLE, SWEEP. Internal counter `cnt` is ADDR_W bits wide. START is 1 if `ZERO_MASK` is set, otherwise 0. MAX is `2**ADDR_W - 1`.
- IDLE, `clear_req=0`:
  - Next `y` is `onehot(a)` if `en=1`, otherwise all zeros.
  - If `ZERO_MASK=1` and `a=0`, next `y` is all zeros.
  - `busy=0`, `sweep_addr=0`.
- IDLE, `clear_req=1`: clear takes priority and the `en`/`a` write is dropped.
  - Next state is SWEEP and `cnt` is loaded with START.
  - Next `y` is `onehot(START)`, `sweep_addr` is START, `busy` is 1.
- SWEEP, `cnt<MAX`:
  - `cnt` increments.
  - Next `y` is `onehot(cnt+1)`, `sweep_addr` is `cnt+1`, `busy` stays 1.
  - `en`, `a` and `clear_req` are ignored.
- SWEEP, `cnt=MAX`:
  - Next state is IDLE, with `y=0`, `busy=0`, `sweep_addr=0`, `done=1`.
  - `en` is ignored on this edge.
- `done` is high for exactly one cycle, the first IDLE cycle after a sweep. During that cycle `en`/`a`/`clear_req` are sampled normally, so a new clear can be accepted back to back.
- Invariant: `y` is one-hot or all zeros, never multi-hot. With `ZERO_MASK=1`, `y[0]` is never 1.
- Counter never wraps: the sweep terminates at MAX.

## Timing
- Reset, asynchronous: `y=0`, `sweep_addr=0`, `busy=0`, `done=0`, `cnt=0`, state IDLE. Takes effect immediately, without waiting for a clock edge.
- Reset during SWEEP aborts the sweep. No `done` pulse is produced. The first post-reset cycle is IDLE.
- Normal-mode latency is 1 cycle: `en`/`a` sampled at edge k appear on `y` after edge k.
- Sweep timing:
  - `clear_req` sampled at edge k.
  - First sweep output after edge k.
  - Sweep length is `2**ADDR_W - START` cycles of `busy=1`.
  - `done` is high for the one cycle after the final sweep output.
- Default parameters give 31 busy cycles (indices 1..31), then `done`.
- All outputs come straight from flops, with no combinational path from inputs to outputs.

## Test plan
- Normal decode, defaults: drive `en=1` with `a` = 0..31 on successive cycles. Each `y` equals `1<<a`, one cycle later. Exception: `a=0` gives `y=32'h0000_0000`. Check `busy=0` and `done=0` throughout.
- Enable gating: `en=0`, `a=5'b10101` gives `y=0`. Set `en=1` and `y=32'h0020_0000` on the next cycle. Build with `ZERO_MASK=0` and drive `a=0`, `en=1`: `y=32'h0000_0001`.
- Clear sweep, defaults: pulse `clear_req` with `en=1`, `a=7`. The write is dropped. Then:
  - 31 cycles follow where `busy=1`, `y=1<<i` and `sweep_addr=i` for i=1..31.
  - Next cycle has `y=0`, `busy=0` and a single-cycle `done=1`.
  - Total of 31 busy cycles.
- Ignored inputs during sweep: toggle `en`, `a` and `clear_req` randomly while `busy=1`. The sweep sequence is unchanged, and no second sweep starts until `clear_req` is seen in IDLE.
- Back-to-back clear: hold `clear_req=1` through the `done` cycle. A new sweep starts immediately after `done`, so `busy` goes high the next cycle with `y=32'h0000_0002`.
- Async reset mid-sweep: assert `rst` between edges while `sweep_addr=12`. `y`, `busy`, `sweep_addr` and `done` go to 0 before the next edge. No `done` follows. Normal decode resumes after `rst` is released.
